// File: rtl/mole_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mole_round_ctrl                                               |
// | Purpose  : Round controller for the whack-a-mole game. Restarts the      |
// |            downstream interval_counter at the start of every show and    |
// |            gap window and consumes its timeout pulse. It picks a         |
// |            pseudo-random mole from an 8-bit LFSR, judges button presses  |
// |            and keeps score / miss / round counts.                        |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            start        - one-cycle pulse, begins a game (IDLE/DONE)     |
// |            btn          - one-cycle-per-press button pulses              |
// |            timeout      - one-cycle pulse from interval_counter          |
// |            ctr_rst_n    - counter reset, low one cycle per window start  |
// |            ctr_interval - window length in seconds, registered          |
// |            ctr_dir      - tied to 0 (counter counts down)                |
// |            mole_oh      - one-hot lit mole, non-zero only in SHOW        |
// |            score/misses - saturating 8-bit hit / miss counters          |
// |            round        - completed rounds                               |
// |            busy / done  - game in progress / game finished              |
// | Options  : MOLE_SPEEDUP_EN - show window shrinks by one second per four  |
// |            hits, never below one second.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mole_round_ctrl #(
  parameter int         N_MOLES = 4,
  parameter int         ROUNDS  = 16,
  parameter int         SHOW_S  = 3,
  parameter int         GAP_S   = 1,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  input  logic               timeout,
  output logic               ctr_rst_n,
  output logic [2:0]         ctr_interval,
  output logic               ctr_dir,
  output logic [N_MOLES-1:0] mole_oh,
  output logic [7:0]         score,
  output logic [7:0]         misses,
  output logic [4:0]         round,
  output logic               busy,
  output logic               done
);

  localparam int         MW        = $clog2(N_MOLES);
  localparam logic [2:0] SHOW_LEN  = 3'(SHOW_S);
  localparam logic [2:0] GAP_LEN   = 3'(GAP_S);
  localparam logic [4:0] ROUNDS_C  = 5'(ROUNDS);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM_SHOW = 3'd1;
  localparam logic [2:0] S_SHOW     = 3'd2;
  localparam logic [2:0] S_RESULT   = 3'd3;
  localparam logic [2:0] S_ARM_GAP  = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]         state;
  logic [2:0]         state_next;

  logic [7:0]         lfsr;
  logic               lfsr_fb;

  logic [MW-1:0]      mole_idx;
  logic               prev_valid;
  logic [MW-1:0]      cand;
  logic [MW-1:0]      pick;
  logic [N_MOLES-1:0] mole_dec;

  logic               hit;
  logic               wrong;
  logic               decide;
  logic               was_hit;

  logic [4:0]         round_inc;
  logic [2:0]         show_len;

  // ---------------------------------------------------------------------
  // Show-window length for the current score.
  // ---------------------------------------------------------------------
`ifdef MOLE_SPEEDUP_EN
  localparam logic [7:0] SHOW_BASE  = 8'(SHOW_S);
  // Length used for the first round of a game, where the score is zero.
  localparam logic [2:0] SHOW_FIRST = (SHOW_S == 0) ? 3'd1 : SHOW_LEN;
  logic [7:0] speed_dec;

  assign speed_dec = {2'b00, score[7:2]};
  assign show_len  = (speed_dec >= SHOW_BASE) ? 3'd1 : 3'(SHOW_BASE - speed_dec);
`else
  localparam logic [2:0] SHOW_FIRST = SHOW_LEN;

  assign show_len = SHOW_LEN;
`endif

  // ---------------------------------------------------------------------
  // LFSR x^8+x^6+x^5+x^4+1, Fibonacci form, shifting towards the MSB.
  // ---------------------------------------------------------------------
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
    end
  end

  // ---------------------------------------------------------------------
  // Mole selection. The first round of a game has no previous mole, so
  // its candidate is taken as-is; later rounds never repeat the last mole.
  // Index wrap is free because N_MOLES is a power of two.
  // ---------------------------------------------------------------------
  assign cand = lfsr[MW-1:0];
  assign pick = (prev_valid && (cand == mole_idx)) ? cand + 1'b1 : cand;

  always_comb begin
    mole_dec           = '0;
    mole_dec[mole_idx] = 1'b1;
  end

  // Press judgement; a correct press wins over a coincident timeout.
  assign hit       = (btn == mole_dec);
  assign wrong     = (btn != '0) && !hit;
  assign decide    = hit || wrong || timeout;
  assign round_inc = round + 5'd1;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_ARM_SHOW;
      S_ARM_SHOW:     state_next = S_SHOW;
      S_SHOW:         if (decide) state_next = S_RESULT;
      S_RESULT:       state_next = (round_inc == ROUNDS_C) ? S_DONE : S_ARM_GAP;
      S_ARM_GAP:      state_next = S_GAP;
      S_GAP:          if (timeout) state_next = S_ARM_SHOW;
      default:        state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. ctr_rst_n also follows rst_n so the counter stays held
  // while this block is itself in reset.
  // ---------------------------------------------------------------------
  always_comb begin
    ctr_rst_n = rst_n;
    mole_oh   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE:     busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_ARM_SHOW: ctr_rst_n = 1'b0;
      S_ARM_GAP:  ctr_rst_n = 1'b0;
      S_SHOW:     mole_oh   = mole_dec;
      default:    ;
    endcase
  end

  assign ctr_dir = 1'b0;

  // ---------------------------------------------------------------------
  // Datapath: counters, mole register and window length. ctr_interval is
  // loaded on the edge that enters an ARM state so it is already valid
  // while the counter is being restarted, and it holds for the window.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score        <= 8'd0;
      misses       <= 8'd0;
      round        <= 5'd0;
      mole_idx     <= '0;
      prev_valid   <= 1'b0;
      was_hit      <= 1'b0;
      ctr_interval <= SHOW_LEN;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score        <= 8'd0;
            misses       <= 8'd0;
            round        <= 5'd0;
            prev_valid   <= 1'b0;
            ctr_interval <= SHOW_FIRST;
          end
        end
        S_ARM_SHOW: begin
          mole_idx   <= pick;
          prev_valid <= 1'b1;
        end
        S_SHOW: begin
          if (decide) was_hit <= hit;
        end
        S_RESULT: begin
          if (was_hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
          end else begin
            if (misses != 8'hFF) misses <= misses + 8'd1;
          end
          round <= round_inc;
          if (round_inc != ROUNDS_C) ctr_interval <= GAP_LEN;
        end
        S_GAP: begin
          if (timeout) ctr_interval <= show_len;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mole_round_ctrl                                            |
// | Purpose  : Self-checking bench for mole_round_ctrl. A behavioural model  |
// |            (LFSR sequence, expected mole choice, game counters) predicts |
// |            every checked output; stimulus choices are randomized.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mole_round_ctrl;

  localparam int         N_MOLES = 4;
  localparam int         ROUNDS  = 16;
  localparam int         SHOW_S  = 3;
  localparam int         GAP_S   = 1;
  localparam logic [7:0] SEED    = 8'hA5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N_MOLES-1:0] btn;
  logic               timeout;
  logic               ctr_rst_n;
  logic [2:0]         ctr_interval;
  logic               ctr_dir;
  logic [N_MOLES-1:0] mole_oh;
  logic [7:0]         score;
  logic [7:0]         misses;
  logic [4:0]         round;
  logic               busy;
  logic               done;

  mole_round_ctrl #(
    .N_MOLES (N_MOLES),
    .ROUNDS  (ROUNDS),
    .SHOW_S  (SHOW_S),
    .GAP_S   (GAP_S),
    .SEED    (SEED)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .btn          (btn),
    .timeout      (timeout),
    .ctr_rst_n    (ctr_rst_n),
    .ctr_interval (ctr_interval),
    .ctr_dir      (ctr_dir),
    .mole_oh      (mole_oh),
    .score        (score),
    .misses       (misses),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference LFSR: next bit is the parity of taps 8,6,5,4 (mask B8).
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    m_lfsr <= (!rst_n) ? SEED : {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  // Game model
  int e_score;
  int e_miss;
  int e_round;
  int e_prev;
  bit e_prev_valid;

  function automatic int exp_show_len(input int sc);
    int v;
`ifdef MOLE_SPEEDUP_EN
    v = SHOW_S - sc / 4;
    if (v < 1) v = 1;
`else
    v = SHOW_S;
`endif
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear;
    e_score      = 0;
    e_miss       = 0;
    e_round      = 0;
    e_prev_valid = 0;
  endtask

  // Entered at #1 into an ARM_SHOW cycle. action: 0 hit, 1 wrong press,
  // 2 timeout, 3 hit together with timeout. Returns at #1 into the next
  // ARM_SHOW cycle, or into DONE after the final round.
  task automatic play_round(input int action);
    int                 cand;
    int                 idx;
    int                 w;
    bit                 is_hit;
    logic [N_MOLES-1:0] oh;
    logic [N_MOLES-1:0] wrongb;

    chk("arm_ctr_rst_n", ctr_rst_n, 0);
    chk("arm_interval", ctr_interval, exp_show_len(e_score));
    chk("arm_mole_off", mole_oh, 0);
    chk("arm_busy", busy, 1);
    cand = int'(m_lfsr) % N_MOLES;
    idx  = (e_prev_valid && cand == e_prev) ? (cand + 1) % N_MOLES : cand;
    e_prev       = idx;
    e_prev_valid = 1;
    oh      = '0;
    oh[idx] = 1'b1;
    btn = N_MOLES'($urandom);   // presses outside SHOW are ignored
    tick;
    btn = '0;
    chk("show_mole", mole_oh, oh);
    chk("show_ctr_rst_n", ctr_rst_n, 1);
    w = $urandom_range(0, 3);
    repeat (w) begin
      tick;
      chk("show_hold", mole_oh, oh);
    end

    case (action)
      0: btn = oh;
      1: begin
        do wrongb = N_MOLES'($urandom); while (wrongb == '0 || wrongb == oh);
        btn = wrongb;
      end
      2: timeout = 1'b1;
      default: begin
        btn     = oh;
        timeout = 1'b1;
      end
    endcase
    tick;
    btn     = '0;
    timeout = 1'($urandom_range(0, 1)); // ignored in RESULT
    chk("result_mole_off", mole_oh, 0);
    chk("result_score_hold", score, e_score);
    chk("result_miss_hold", misses, e_miss);

    is_hit = (action == 0 || action == 3);
    if (is_hit) e_score = (e_score == 255) ? 255 : e_score + 1;
    else        e_miss  = (e_miss == 255) ? 255 : e_miss + 1;
    e_round++;

    tick;
    timeout = 1'b0;
    chk("score", score, e_score);
    chk("misses", misses, e_miss);
    chk("round", round, e_round);

    if (e_round == ROUNDS) begin
      chk("done_flag", done, 1);
      chk("done_busy", busy, 0);
      chk("done_ctr_rst_n", ctr_rst_n, 1);
    end else begin
      chk("gap_arm_ctr_rst_n", ctr_rst_n, 0);
      chk("gap_interval", ctr_interval, GAP_S);
      timeout = 1'($urandom_range(0, 1)); // ignored in ARM_GAP
      tick;
      timeout = 1'b0;
      w = $urandom_range(1, 3);
      for (int i = 0; i < w; i++) begin
        btn   = N_MOLES'($urandom);
        start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tick;
        btn   = '0;
        start = 1'b0;
        chk("gap_ctr_rst_n", ctr_rst_n, 1);
        chk("gap_mole_off", mole_oh, 0);
        chk("gap_busy", busy, 1);
        chk("gap_round", round, e_round);
        chk("gap_interval_hold", ctr_interval, GAP_S);
      end
      timeout = 1'b1;
      tick;
      timeout = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    btn     = '0;
    timeout = 1'b0;
    model_clear();

    #1;
    chk("in_reset_ctr_rst_n", ctr_rst_n, 0);
    repeat (3) tick;
    chk("rst_mole", mole_oh, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ctr_rst_n", ctr_rst_n, 0);
    chk("rst_interval", ctr_interval, SHOW_S);
    chk("rst_dir", ctr_dir, 0);

    // Release reset; timeout and buttons in IDLE do nothing.
    rst_n   = 1'b1;
    timeout = 1'b1;
    btn     = N_MOLES'($urandom);
    tick;
    timeout = 1'b0;
    btn     = '0;
    chk("idle_ctr_rst_n", ctr_rst_n, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Game 1: the four outcome kinds first, then random outcomes.
    start = 1'b1;
    tick;
    start = 1'b0;
    model_clear();
    for (int r = 0; r < ROUNDS; r++) begin
      play_round((r < 4) ? r : $urandom_range(0, 3));
    end

    // DONE holds against timeout and buttons.
    repeat (3) begin
      timeout = 1'b1;
      btn     = N_MOLES'($urandom);
      tick;
      timeout = 1'b0;
      btn     = '0;
      chk("done_hold", done, 1);
      chk("done_round_hold", round, ROUNDS);
      chk("done_score_hold", score, e_score);
      chk("done_miss_hold", misses, e_miss);
    end

    // Game 2: restart clears counters; all hits exercise the speed-up path.
    start = 1'b1;
    tick;
    start = 1'b0;
    model_clear();
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_round", round, 0);
    for (int r = 0; r < 13; r++) play_round(0);

    // Reset in the middle of a SHOW window.
    tick;
    chk("mid_show_busy", busy, 1);
    rst_n = 1'b0;
    tick;
    model_clear();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_mole", mole_oh, 0);
    chk("midrst_score", score, 0);
    chk("midrst_misses", misses, 0);
    chk("midrst_round", round, 0);
    chk("midrst_ctr_rst_n", ctr_rst_n, 0);
    chk("midrst_interval", ctr_interval, SHOW_S);
    rst_n = 1'b1;
    tick;
    chk("postrst_ctr_rst_n", ctr_rst_n, 1);

    // Game 3: a couple of rounds after the reset.
    start = 1'b1;
    tick;
    start = 1'b0;
    play_round(0);
    play_round(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
